// File: rtl/cart_bus_responder.sv
// rtl/cart_bus_responder.sv - N64 cartridge bus responder: address latch, ROM prefetch, AD drive
module cart_bus_responder #(
    parameter int          ROM_ADDR_W = 26,
    parameter logic [31:0] BASE_ADDR  = 32'h1000_0000,
    parameter logic [31:0] ADDR_MASK  = 32'hF000_0000
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [15:0]           cart_ad_sync,
    input  logic                  cart_rd_sync,
    input  logic                  cart_alel_sync,
    input  logic                  cart_aleh_sync,
    output logic [15:0]           cart_ad_out,
    output logic                  cart_ad_oe,
    output logic                  rom_req,
    output logic [ROM_ADDR_W-1:0] rom_addr,
    input  logic                  rom_ack,
    input  logic [15:0]           rom_data,
    output logic                  err_underrun,
    output logic                  access_active
);

    typedef enum logic [2:0] {IDLE, FETCH, READY, DRIVE, DRAIN} state_t;

    state_t      state;
    logic [15:0] ad_q;
    logic        aleh_q;
    logic        alel_q;
    logic        rd_q;
    logic [31:0] addr;
    logic [15:0] data_buf;
    logic        pend_rd;
    logic        pend_addr;

    logic        fall_aleh;
    logic        rise_aleh;
    logic        fall_alel;
    logic        fall_rd;
    logic        rise_rd;
    logic        new_addr;
    logic        abort;
    logic        ack;
    logic [31:0] addr_eff;
    logic        eff_hit;
    logic        restart;
    logic [31:0] addr_inc;

    // Word-aligned ROM address for a bus address
    function automatic logic [ROM_ADDR_W-1:0] word_of(input logic [31:0] a);
        return {a[ROM_ADDR_W-1:1], 1'b0};
    endfunction

    // Previous-cycle copies of the synchronized bus signals for edge detection
    always_ff @(posedge clk) begin
        if (reset) begin
            ad_q   <= '0;
            aleh_q <= 1'b0;
            alel_q <= 1'b0;
            rd_q   <= 1'b1;
        end else begin
            ad_q   <= cart_ad_sync;
            aleh_q <= cart_aleh_sync;
            alel_q <= cart_alel_sync;
            rd_q   <= cart_rd_sync;
        end
    end

    // Edge decode, effective address (including this cycle's capture) and hit test
    always_comb begin
        fall_aleh = aleh_q & ~cart_aleh_sync;
        rise_aleh = ~aleh_q & cart_aleh_sync;
        fall_alel = alel_q & ~cart_alel_sync;
        fall_rd   = rd_q & ~cart_rd_sync;
        rise_rd   = ~rd_q & cart_rd_sync;
        new_addr  = fall_alel;
        abort     = rise_aleh | new_addr;
        ack       = rom_ack & rom_req;
        addr_eff  = {(fall_aleh ? ad_q : addr[31:16]), (new_addr ? ad_q : addr[15:0])};
        eff_hit   = (addr_eff & ADDR_MASK) == BASE_ADDR;
        restart   = new_addr & eff_hit & ~rise_aleh;
        addr_inc  = addr;
        addr_inc[ROM_ADDR_W-1:0] = addr[ROM_ADDR_W-1:0] + ROM_ADDR_W'(2);
    end

    assign access_active = (state == FETCH) || (state == READY) || (state == DRIVE);

    // Address capture plus the transfer FSM with registered bus and ROM outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= IDLE;
            addr         <= '0;
            data_buf     <= '0;
            pend_rd      <= 1'b0;
            pend_addr    <= 1'b0;
            cart_ad_out  <= '0;
            cart_ad_oe   <= 1'b0;
            rom_req      <= 1'b0;
            rom_addr     <= '0;
            err_underrun <= 1'b0;
        end else begin
            if (fall_aleh) addr[31:16] <= ad_q;
            if (fall_alel) addr[15:0]  <= ad_q;

            case (state)
                IDLE: begin
                    if (restart) begin
                        state    <= FETCH;
                        rom_req  <= 1'b1;
                        rom_addr <= word_of(addr_eff);
                        pend_rd  <= 1'b0;
                    end
                end

                FETCH: begin
                    if (ack) begin
                        rom_req  <= 1'b0;
                        data_buf <= rom_data;
                        pend_rd  <= 1'b0;
                        if (abort) begin
                            // The ack already retired the stale fetch, so no drain is needed
                            if (restart) begin
                                state    <= FETCH;
                                rom_req  <= 1'b1;
                                rom_addr <= word_of(addr_eff);
                            end else begin
                                state <= IDLE;
                            end
                        end else if (pend_rd || fall_rd) begin
                            err_underrun <= 1'b1;
                            if (!cart_rd_sync) begin
                                state       <= DRIVE;
                                cart_ad_out <= rom_data;
                                cart_ad_oe  <= 1'b1;
                            end else begin
                                state <= READY;
                            end
                        end else begin
                            state <= READY;
                        end
                    end else if (abort) begin
                        // Request must stay up until the controller acks it
                        state     <= DRAIN;
                        pend_addr <= new_addr;
                        pend_rd   <= 1'b0;
                    end else if (fall_rd) begin
                        pend_rd <= 1'b1;
                    end
                end

                READY, DRIVE: begin
                    if (abort) begin
                        cart_ad_oe <= 1'b0;
                        if (restart) begin
                            state    <= FETCH;
                            rom_req  <= 1'b1;
                            rom_addr <= word_of(addr_eff);
                            pend_rd  <= 1'b0;
                        end else begin
                            state <= IDLE;
                        end
                    end else if (state == READY) begin
                        if (fall_rd) begin
                            state       <= DRIVE;
                            cart_ad_out <= data_buf;
                            cart_ad_oe  <= 1'b1;
                        end
                    end else if (rise_rd) begin
                        cart_ad_oe                <= 1'b0;
                        addr[ROM_ADDR_W-1:0]      <= addr_inc[ROM_ADDR_W-1:0];
                        rom_req                   <= 1'b1;
                        rom_addr                  <= word_of(addr_inc);
                        pend_rd                   <= 1'b0;
                        state                     <= FETCH;
                    end
                end

                DRAIN: begin
                    if (rise_aleh)     pend_addr <= 1'b0;
                    else if (new_addr) pend_addr <= 1'b1;
                    if (ack) begin
                        pend_addr <= 1'b0;
                        if ((pend_addr || new_addr) && eff_hit && !rise_aleh) begin
                            state    <= FETCH;
                            rom_addr <= word_of(addr_eff);
                        end else begin
                            rom_req <= 1'b0;
                            state   <= IDLE;
                        end
                    end
                end

                default: begin
                    state      <= IDLE;
                    rom_req    <= 1'b0;
                    cart_ad_oe <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_cart_bus_responder.sv
// tb/tb_cart_bus_responder.sv - self-checking bench for cart_bus_responder
module tb_cart_bus_responder;

    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] cart_ad_sync;
    logic        cart_rd_sync;
    logic        cart_alel_sync;
    logic        cart_aleh_sync;
    logic [15:0] cart_ad_out;
    logic        cart_ad_oe;
    logic        rom_req;
    logic [25:0] rom_addr;
    logic        rom_ack;
    logic [15:0] rom_data;
    logic        err_underrun;
    logic        access_active;

    always #5 clk = ~clk;

    cart_bus_responder dut (
        .clk           (clk),
        .reset         (reset),
        .cart_ad_sync  (cart_ad_sync),
        .cart_rd_sync  (cart_rd_sync),
        .cart_alel_sync(cart_alel_sync),
        .cart_aleh_sync(cart_aleh_sync),
        .cart_ad_out   (cart_ad_out),
        .cart_ad_oe    (cart_ad_oe),
        .rom_req       (rom_req),
        .rom_addr      (rom_addr),
        .rom_ack       (rom_ack),
        .rom_data      (rom_data),
        .err_underrun  (err_underrun),
        .access_active (access_active)
    );

    typedef struct {
        logic [15:0] data;
        int          len;
        int          lat;
    } dexp_t;

    typedef struct {
        logic [15:0] hi;
        logic [15:0] lo;
        int          pulses;
        int          delay;
        logic        hit;
        logic [25:0] rom0;
    } vec_t;

    int          checks = 0;
    int          errors = 0;
    int          ack_delay = 2;
    int          n_req = 0;
    int          n_oe = 0;
    dexp_t       data_q[$];
    logic [25:0] addr_q[$];

    function automatic logic [15:0] rom_word(input logic [25:0] a);
        return a[16:1] ^ {a[8:1], a[25:18]} ^ 16'h5A3C;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic bus_addr(input logic [15:0] hi, input logic [15:0] lo);
        cart_ad_sync   = hi;
        cart_aleh_sync = 1'b1;
        cart_alel_sync = 1'b1;
        tick();
        tick();
        cart_aleh_sync = 1'b0;
        cart_ad_sync   = lo;
        tick();
        tick();
        cart_alel_sync = 1'b0;
        tick();
    endtask

    task automatic rd_pulse(input int lo_cyc, input int hi_cyc);
        cart_rd_sync = 1'b0;
        repeat (lo_cyc) tick();
        cart_rd_sync = 1'b1;
        repeat (hi_cyc) tick();
    endtask

    task automatic push_data(input logic [25:0] a, input int len, input int lat);
        dexp_t d;
        d.data = rom_word(a);
        d.len  = len;
        d.lat  = lat;
        data_q.push_back(d);
    endtask

    // ROM model: acks ack_delay cycles into each request with the addressed word
    initial begin : rom_model
        int cnt;
        cnt      = 0;
        rom_ack  = 1'b0;
        rom_data = '0;
        forever begin
            tick();
            rom_ack = 1'b0;
            if (rom_req && !reset) begin
                cnt++;
                if (cnt >= ack_delay) begin
                    rom_ack  = 1'b1;
                    rom_data = rom_word(rom_addr);
                    cnt      = 0;
                end
            end else begin
                cnt = 0;
            end
        end
    end

    // Scoreboard: request starts pop expected addresses, oe rises pop expected words
    initial begin : monitor
        logic        prev_req;
        logic        prev_ack;
        logic        prev_oe;
        int          rd_low;
        int          oe_len;
        int          cur_len;
        dexp_t       d;
        logic [25:0] ea;
        prev_req = 1'b0;
        prev_ack = 1'b0;
        prev_oe  = 1'b0;
        rd_low   = 0;
        oe_len   = 0;
        cur_len  = 0;
        forever begin
            @(negedge clk);
            if (cart_rd_sync === 1'b0) rd_low++;
            else rd_low = 0;
            if (rom_req && (!prev_req || prev_ack)) begin
                n_req++;
                if (addr_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL rom_req_unexpected: rom_addr %h with none expected", rom_addr);
                end else begin
                    ea = addr_q.pop_front();
                    check("rom_addr", 32'(rom_addr), 32'(ea));
                end
            end
            if (cart_ad_oe && !prev_oe) begin
                n_oe++;
                oe_len = 0;
                if (data_q.size() == 0) begin
                    checks++;
                    errors++;
                    cur_len = 0;
                    $display("FAIL oe_unexpected: ad_out %h with none expected", cart_ad_out);
                end else begin
                    d = data_q.pop_front();
                    check("ad_data", 32'(cart_ad_out), 32'(d.data));
                    cur_len = d.len;
                    if (d.lat != 0) check("oe_latency", rd_low, d.lat);
                end
            end
            if (cart_ad_oe) oe_len++;
            if (!cart_ad_oe && prev_oe && cur_len != 0) check("oe_width", oe_len, cur_len);
            prev_req = rom_req;
            prev_ack = rom_ack;
            prev_oe  = cart_ad_oe;
        end
    end

    initial begin : stim
        vec_t vecs[6];
        int   r0;
        int   o0;
        bit   seen;

        vecs[0] = '{16'h1000, 16'h0040, 4, 2, 1'b1, 26'h0000040};
        vecs[1] = '{16'h0500, 16'h0000, 2, 2, 1'b0, 26'h0000000};
        vecs[2] = '{16'h13FF, 16'hFFFE, 2, 2, 1'b1, 26'h3FFFFFE};
        vecs[3] = '{16'h1234, 16'h5678, 3, 5, 1'b1, 26'h2345678};
        vecs[4] = '{16'h2000, 16'h0010, 1, 1, 1'b0, 26'h0000000};
        vecs[5] = '{16'h1FFF, 16'h0001, 2, 3, 1'b1, 26'h3FF0000};

        reset          = 1'b1;
        cart_ad_sync   = '0;
        cart_rd_sync   = 1'b1;
        cart_alel_sync = 1'b0;
        cart_aleh_sync = 1'b0;
        repeat (3) tick();
        check("rst_oe", 32'(cart_ad_oe), 32'd0);
        check("rst_ad_out", 32'(cart_ad_out), 32'd0);
        check("rst_rom_req", 32'(rom_req), 32'd0);
        check("rst_rom_addr", 32'(rom_addr), 32'd0);
        check("rst_err", 32'(err_underrun), 32'd0);
        check("rst_active", 32'(access_active), 32'd0);
        reset = 1'b0;
        tick();

        for (int i = 0; i < 6; i++) begin
            ack_delay = vecs[i].delay;
            r0 = n_req;
            o0 = n_oe;
            if (vecs[i].hit) begin
                for (int k = 0; k <= vecs[i].pulses; k++) begin
                    addr_q.push_back(vecs[i].rom0 + 26'(2 * k));
                    if (k < vecs[i].pulses) push_data(vecs[i].rom0 + 26'(2 * k), 8, 2);
                end
            end
            bus_addr(vecs[i].hi, vecs[i].lo);
            repeat (6) tick();
            for (int p = 0; p < vecs[i].pulses; p++) rd_pulse(8, 8);
            repeat (8) tick();
            check("req_count", n_req - r0, vecs[i].hit ? vecs[i].pulses + 1 : 0);
            check("oe_count", n_oe - o0, vecs[i].hit ? vecs[i].pulses : 0);
        end
        check("no_underrun", 32'(err_underrun), 32'd0);

        // Underrun: RD falls while the fetch is still outstanding
        ack_delay = 10;
        addr_q.push_back(26'h0000100);
        addr_q.push_back(26'h0000102);
        push_data(26'h0000100, 0, 0);
        bus_addr(16'h1000, 16'h0100);
        tick();
        tick();
        cart_rd_sync = 1'b0;
        seen = 1'b0;
        for (int c = 0; c < 30 && !seen; c++) begin
            @(negedge clk);
            if (rom_ack) seen = 1'b1;
        end
        check("underrun_ack_seen", 32'(seen), 32'd1);
        @(negedge clk);
        check("underrun_oe", 32'(cart_ad_oe), 32'd1);
        check("underrun_data", 32'(cart_ad_out), 32'(rom_word(26'h0000100)));
        check("underrun_err", 32'(err_underrun), 32'd1);
        tick();
        tick();
        cart_rd_sync = 1'b1;
        repeat (20) tick();
        check("underrun_sticky", 32'(err_underrun), 32'd1);
        check("underrun_oe_off", 32'(cart_ad_oe), 32'd0);

        // New address cycle while a fetch is pending
        ack_delay = 12;
        addr_q.push_back(26'h0000200);
        addr_q.push_back(26'h0000300);
        addr_q.push_back(26'h0000302);
        push_data(26'h0000300, 8, 2);
        bus_addr(16'h1000, 16'h0200);
        bus_addr(16'h1000, 16'h0300);
        check("drain_req_held", 32'(rom_req), 32'd1);
        check("drain_addr_held", 32'(rom_addr), 32'h200);
        check("drain_oe", 32'(cart_ad_oe), 32'd0);
        repeat (30) tick();
        rd_pulse(8, 8);
        repeat (16) tick();

        // Reset while driving AD
        ack_delay = 2;
        addr_q.push_back(26'h0000400);
        push_data(26'h0000400, 0, 2);
        bus_addr(16'h1000, 16'h0400);
        repeat (6) tick();
        cart_rd_sync = 1'b0;
        repeat (3) tick();
        check("pre_reset_oe", 32'(cart_ad_oe), 32'd1);
        reset        = 1'b1;
        cart_rd_sync = 1'b1;
        tick();
        check("mid_rst_oe", 32'(cart_ad_oe), 32'd0);
        check("mid_rst_ad_out", 32'(cart_ad_out), 32'd0);
        check("mid_rst_req", 32'(rom_req), 32'd0);
        check("mid_rst_err", 32'(err_underrun), 32'd0);
        check("mid_rst_active", 32'(access_active), 32'd0);
        reset = 1'b0;
        tick();

        // Reset while a request is outstanding
        ack_delay = 8;
        addr_q.push_back(26'h0000500);
        bus_addr(16'h1000, 16'h0500);
        tick();
        tick();
        check("pre_reset_req", 32'(rom_req), 32'd1);
        reset = 1'b1;
        tick();
        check("req_rst_req", 32'(rom_req), 32'd0);
        check("req_rst_addr", 32'(rom_addr), 32'd0);
        check("req_rst_active", 32'(access_active), 32'd0);
        reset     = 1'b0;
        ack_delay = 2;
        tick();

        // Normal transfer after reset
        addr_q.push_back(26'h0000600);
        addr_q.push_back(26'h0000602);
        push_data(26'h0000600, 8, 2);
        bus_addr(16'h1000, 16'h0600);
        repeat (6) tick();
        rd_pulse(8, 8);
        repeat (6) tick();

        check("addr_q_empty", addr_q.size(), 0);
        check("data_q_empty", data_q.size(), 0);
        check("final_err", 32'(err_underrun), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
